// File: rtl/stream_demux_n.sv
// stream_demux_n -- registered 1-to-CHANNELS stream demultiplexer.
//
// A packet is routed to the channel named by S on its first beat. The
// channel is then held until the beat marked LAST is accepted. Each output
// channel has a one-entry register. A packet whose first-beat select is out
// of range (S >= CHANNELS) is accepted and discarded. DROP pulses once for
// each discarded beat.
//
// Ports:
//   CLK       rising-edge clock
//   RST       asynchronous, active-high reset
//   D         input beat data (WIDTH bits)
//   S         destination channel, sampled only on the first beat of a packet
//   LAST      final beat of a packet
//   IN_VALID  input beat valid
//   IN_READY  block can accept a beat this cycle (combinational)
//   Y         output data, channel k at [k*WIDTH +: WIDTH]
//   Y_LAST    per-channel LAST
//   Y_VALID   per-channel valid
//   Y_READY   per-channel ready
//   DROP      registered one-cycle pulse per discarded beat
//   CNT       per-channel accepted-beat counters, channel k at [k*16 +: 16]
//
// Build option:
//   DEMUX_COUNT_EN  when defined, CNT counts routed beats per channel
//                   (16-bit, wrapping). When undefined, CNT is tied to zero.
module stream_demux_n #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SELW     = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [WIDTH-1:0]         D,
  input  logic [SELW-1:0]          S,
  input  logic                     LAST,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  output logic [CHANNELS*WIDTH-1:0] Y,
  output logic [CHANNELS-1:0]      Y_LAST,
  output logic [CHANNELS-1:0]      Y_VALID,
  input  logic [CHANNELS-1:0]      Y_READY,
  output logic                     DROP,
  output logic [CHANNELS*16-1:0]   CNT
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_LOCKED   = 2'd1;
  localparam logic [1:0] ST_DROPPING = 2'd2;

  // S is zero-extended by one bit so that the range check also works when
  // CHANNELS == 2**SELW.
  localparam logic [SELW:0] CH_LIMIT = (SELW+1)'(CHANNELS);

  logic [1:0]                state_r;
  logic [1:0]                state_next_s;
  logic [SELW-1:0]           lock_sel_r;
  logic [SELW-1:0]           target_sel_s;
  logic                      in_range_s;
  logic                      drop_beat_s;
  logic                      accept_s;
  logic                      routed_s;
  logic [CHANNELS-1:0]       target_oh_s;
  logic [CHANNELS-1:0]       load_s;
  logic [CHANNELS-1:0]       y_valid_r;
  logic [CHANNELS-1:0]       y_last_r;
  logic [CHANNELS*WIDTH-1:0] y_data_r;
  logic                      drop_r;

  assign in_range_s = ({1'b0, S} < CH_LIMIT);

  // Target channel: the live select at a packet start, otherwise the lock.
  always_comb begin
    target_sel_s = lock_sel_r;
    case (state_r)
      ST_IDLE: target_sel_s = S;
      default: target_sel_s = lock_sel_r;
    endcase
  end

  // One-hot decode of the target. An out-of-range S decodes to all zeros.
  always_comb begin
    target_oh_s = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      target_oh_s[k] = (target_sel_s == SELW'(k));
    end
  end

  // Determine whether the beat currently offered would be discarded.
  always_comb begin
    drop_beat_s = 1'b0;
    case (state_r)
      ST_DROPPING: drop_beat_s = 1'b1;
      ST_IDLE:     drop_beat_s = ~in_range_s;
      default:     drop_beat_s = 1'b0;
    endcase
  end

  // A discarded beat is always accepted. A routed beat is accepted when the
  // target slot is empty or draining in this same cycle.
  assign IN_READY = drop_beat_s | (|(target_oh_s & (~y_valid_r | Y_READY)));
  assign accept_s = IN_VALID & IN_READY;
  assign routed_s = accept_s & ~drop_beat_s;
  assign load_s   = target_oh_s & {CHANNELS{routed_s}};

  // Next-state logic for packet lock and drop tracking.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s & ~LAST) begin
          state_next_s = in_range_s ? ST_LOCKED : ST_DROPPING;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOCKED, ST_DROPPING: begin
        if (accept_s & LAST) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = state_r;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, lock register and drop pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r    <= ST_IDLE;
      lock_sel_r <= '0;
      drop_r     <= 1'b0;
    end else begin
      state_r <= state_next_s;
      drop_r  <= accept_s & drop_beat_s;
      if ((state_r == ST_IDLE) && accept_s && in_range_s && !LAST) begin
        lock_sel_r <= S;
      end else begin
        lock_sel_r <= lock_sel_r;
      end
    end
  end

  // Per-channel output slots. A reload wins over a drain in the same cycle.
  // Data and LAST hold their value once the slot empties.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      y_valid_r <= '0;
      y_last_r  <= '0;
      y_data_r  <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (load_s[k]) begin
          y_data_r[k*WIDTH +: WIDTH] <= D;
          y_last_r[k]                <= LAST;
          y_valid_r[k]               <= 1'b1;
        end else if (Y_READY[k]) begin
          y_valid_r[k] <= 1'b0;
        end else begin
          y_valid_r[k] <= y_valid_r[k];
        end
      end
    end
  end

  assign Y       = y_data_r;
  assign Y_LAST  = y_last_r;
  assign Y_VALID = y_valid_r;
  assign DROP    = drop_r;

`ifdef DEMUX_COUNT_EN
  logic [CHANNELS*16-1:0] cnt_r;

  // Routed-beat counters. They wrap naturally at 16 bits.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_r <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (load_s[k]) begin
          cnt_r[k*16 +: 16] <= cnt_r[k*16 +: 16] + 16'd1;
        end else begin
          cnt_r[k*16 +: 16] <= cnt_r[k*16 +: 16];
        end
      end
    end
  end

  assign CNT = cnt_r;
`else
  assign CNT = '0;
`endif

endmodule

// File: tb/tb_stream_demux_n.sv
// Self-checking bench for stream_demux_n. The main instance uses 4 channels.
// A second instance with 3 channels exercises out-of-range drops. A
// packet-level reference model predicts every output.
module tb_stream_demux_n;

  logic        clk;
  logic        rst;
  logic [7:0]  d;
  logic [1:0]  s;
  logic        last;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] y;
  logic [3:0]  y_last;
  logic [3:0]  y_valid;
  logic [3:0]  y_ready;
  logic        drop;
  logic [63:0] cnt;

  logic [7:0]  d3;
  logic [1:0]  s3;
  logic        last3;
  logic        in3_valid;
  logic        in3_ready;
  logic [23:0] y3;
  logic [2:0]  y3_last;
  logic [2:0]  y3_valid;
  logic [2:0]  y3_ready;
  logic        drop3;
  logic [47:0] cnt3;

  int errors = 0;
  int checks = 0;

  // Reference model: per-channel buffer contents plus packet state.
  logic [3:0]  m_yv;
  logic [3:0]  m_yl;
  logic [31:0] m_y;
  logic [63:0] m_cnt;
  logic        m_drop;
  logic        m_inpkt;
  logic        m_dropping;
  int          m_sel;
  logic        obs_ready;
  logic        exp_ready;

  stream_demux_n #(.WIDTH(8), .CHANNELS(4), .SELW(2)) dut (
    .CLK(clk), .RST(rst), .D(d), .S(s), .LAST(last), .IN_VALID(in_valid),
    .IN_READY(in_ready), .Y(y), .Y_LAST(y_last), .Y_VALID(y_valid),
    .Y_READY(y_ready), .DROP(drop), .CNT(cnt)
  );

  stream_demux_n #(.WIDTH(8), .CHANNELS(3), .SELW(2)) dut3 (
    .CLK(clk), .RST(rst), .D(d3), .S(s3), .LAST(last3), .IN_VALID(in3_valid),
    .IN_READY(in3_ready), .Y(y3), .Y_LAST(y3_last), .Y_VALID(y3_valid),
    .Y_READY(y3_ready), .DROP(drop3), .CNT(cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_yv = '0; m_yl = '0; m_y = '0; m_cnt = '0; m_drop = 1'b0;
    m_inpkt = 1'b0; m_dropping = 1'b0; m_sel = 0;
  endtask

  function automatic logic model_ready(input logic [1:0] sel, input logic [3:0] yr);
    int t;
    if (m_dropping) return 1'b1;
    t = m_inpkt ? m_sel : int'(sel);
    return !m_yv[t] || yr[t];
  endfunction

  task automatic model_route(input int t, input logic [7:0] data, input logic lst);
    m_y[t*8 +: 8]    = data;
    m_yl[t]          = lst;
    m_yv[t]          = 1'b1;
    m_cnt[t*16 +: 16] = m_cnt[t*16 +: 16] + 16'd1;
  endtask

  task automatic model_step(input logic acc, input logic [7:0] data,
                            input logic [1:0] sel, input logic lst,
                            input logic [3:0] yr);
    m_yv   = m_yv & ~yr;
    m_drop = 1'b0;
    if (acc) begin
      if (m_dropping) begin
        m_drop = 1'b1;
        if (lst) m_dropping = 1'b0;
      end else if (m_inpkt) begin
        model_route(m_sel, data, lst);
        if (lst) m_inpkt = 1'b0;
      end else begin
        model_route(int'(sel), data, lst);
        if (!lst) begin
          m_inpkt = 1'b1;
          m_sel   = int'(sel);
        end
      end
    end
  endtask

  function automatic logic [63:0] exp_cnt();
`ifdef DEMUX_COUNT_EN
    return m_cnt;
`else
    return 64'd0;
`endif
  endfunction

  // One clock cycle: drive inputs, sample IN_READY, advance the model,
  // and return at the falling edge where registered outputs are stable.
  task automatic cycle(input logic iv, input logic [7:0] data, input logic [1:0] sel,
                       input logic lst, input logic [3:0] yr);
    in_valid = iv; d = data; s = sel; last = lst; y_ready = yr;
    #1;
    obs_ready = in_ready;
    exp_ready = model_ready(sel, yr);
    @(posedge clk);
    model_step(iv & exp_ready, data, sel, lst, yr);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (y_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b expected 0000", y_valid); end
    checks++; if (y !== 32'd0) begin errors++; $display("FAIL reset_y: got %h expected 0", y); end
    checks++; if (cnt !== 64'd0) begin errors++; $display("FAIL reset_cnt: got %h expected 0", cnt); end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    // Lock onto channel 2 with its slot held full, then reset mid-packet.
    cycle(1'b1, 8'hA0, 2'd2, 1'b0, 4'b0000);
    checks++; if (y_valid !== 4'b0100) begin errors++; $display("FAIL reset_setup: got %b expected 0100", y_valid); end
    rst = 1'b1;
    #1;
    checks++; if (y_valid !== 4'b0000) begin errors++; $display("FAIL reset_mid_valid: got %b expected 0000", y_valid); end
    checks++; if (y !== 32'd0 || y_last !== 4'd0) begin errors++; $display("FAIL reset_mid_y: got %h/%b expected 0/0", y, y_last); end
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL reset_mid_drop: got %b expected 0", drop); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 8'h3C, 2'd1, 1'b1, 4'b1111);
    checks++; if (y_valid !== 4'b0010) begin errors++; $display("FAIL reset_next: got %b expected 0010", y_valid); end
    checks++; if (y[15:8] !== 8'h3C) begin errors++; $display("FAIL reset_next_data: got %h expected 3c", y[15:8]); end
    cycle(1'b0, 8'h00, 2'd0, 1'b0, 4'b1111);
  endtask

  task automatic test_packet_lock();
    logic [7:0] bytes [3];
    logic [1:0] sels  [3];
    bytes[0] = 8'hA1; bytes[1] = 8'hA2; bytes[2] = 8'hA3;
    sels[0] = 2'd2;   sels[1] = 2'd0;   sels[2] = 2'd0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, bytes[i], sels[i], (i == 2), 4'b1111);
      checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL lock_ready[%0d]: got %b expected 1", i, obs_ready); end
      checks++; if (y_valid !== 4'b0100) begin errors++; $display("FAIL lock_valid[%0d]: got %b expected 0100", i, y_valid); end
      checks++; if (y[23:16] !== bytes[i]) begin errors++; $display("FAIL lock_data[%0d]: got %h expected %h", i, y[23:16], bytes[i]); end
      checks++; if (y_last[2] !== (i == 2)) begin errors++; $display("FAIL lock_last[%0d]: got %b expected %b", i, y_last[2], (i == 2)); end
    end
    cycle(1'b0, 8'h00, 2'd0, 1'b0, 4'b1111);
    checks++; if (y_valid !== 4'b0000) begin errors++; $display("FAIL lock_drain: got %b expected 0000", y_valid); end
  endtask

  task automatic test_backpressure();
    cycle(1'b1, 8'h33, 2'd3, 1'b1, 4'b0000);
    cycle(1'b1, 8'h11, 2'd1, 1'b0, 4'b0000);
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL bp_first_ready: got %b expected 1", obs_ready); end
    cycle(1'b1, 8'h12, 2'd1, 1'b0, 4'b0000);
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready: got %b expected 0", obs_ready); end
    checks++; if (y[15:8] !== 8'h11 || y_valid !== 4'b1010) begin errors++; $display("FAIL bp_hold: got %h/%b expected 11/1010", y[15:8], y_valid); end
    cycle(1'b1, 8'h12, 2'd1, 1'b0, 4'b1000);
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL bp_stall2_ready: got %b expected 0", obs_ready); end
    checks++; if (y_valid !== 4'b0010 || y[15:8] !== 8'h11) begin errors++; $display("FAIL bp_ch3_drain: got %b/%h expected 0010/11", y_valid, y[15:8]); end
    cycle(1'b1, 8'h12, 2'd1, 1'b0, 4'b0010);
    checks++; if (obs_ready !== 1'b1 || y[15:8] !== 8'h12) begin errors++; $display("FAIL bp_resume1: got %b/%h expected 1/12", obs_ready, y[15:8]); end
    cycle(1'b1, 8'h13, 2'd1, 1'b1, 4'b0010);
    checks++; if (obs_ready !== 1'b1 || y[15:8] !== 8'h13 || y_valid !== 4'b0010) begin errors++; $display("FAIL bp_resume2: got %b/%h/%b expected 1/13/0010", obs_ready, y[15:8], y_valid); end
    cycle(1'b0, 8'h00, 2'd0, 1'b0, 4'b1111);
  endtask

  task automatic test_throughput();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 8'h80 + 8'(i), 2'(i % 4), 1'b1, 4'b1111);
      checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL tp_ready[%0d]: got %b expected 1", i, obs_ready); end
      checks++; if (y_valid !== (4'b0001 << (i % 4))) begin errors++; $display("FAIL tp_valid[%0d]: got %b expected %b", i, y_valid, 4'b0001 << (i % 4)); end
      checks++; if (y[(i % 4)*8 +: 8] !== 8'h80 + 8'(i)) begin errors++; $display("FAIL tp_data[%0d]: got %h expected %h", i, y[(i % 4)*8 +: 8], 8'h80 + 8'(i)); end
    end
    cycle(1'b0, 8'h00, 2'd0, 1'b0, 4'b1111);
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      cycle(($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom), ($urandom_range(0, 2) == 0), 4'($urandom));
      checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d]: got %b expected %b", i, obs_ready, exp_ready); end
      checks++; if (y_valid !== m_yv) begin errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, y_valid, m_yv); end
      checks++; if (y !== m_y) begin errors++; $display("FAIL rnd_data[%0d]: got %h expected %h", i, y, m_y); end
      checks++; if (y_last !== m_yl) begin errors++; $display("FAIL rnd_last[%0d]: got %b expected %b", i, y_last, m_yl); end
      checks++; if (drop !== m_drop) begin errors++; $display("FAIL rnd_drop[%0d]: got %b expected %b", i, drop, m_drop); end
      checks++; if (cnt !== exp_cnt()) begin errors++; $display("FAIL rnd_cnt[%0d]: got %h expected %h", i, cnt, exp_cnt()); end
    end
    cycle(1'b0, 8'h00, 2'd0, 1'b0, 4'b1111);
  endtask

  task automatic test_out_of_range();
    for (int i = 0; i < 3; i++) begin
      in3_valid = 1'b1; d3 = 8'hD0 + 8'(i); s3 = 2'd3; last3 = (i == 2);
      #1;
      checks++; if (in3_ready !== 1'b1) begin errors++; $display("FAIL oor_ready[%0d]: got %b expected 1", i, in3_ready); end
      cycle(1'b0, 8'h00, 2'd0, 1'b0, 4'b1111);
      checks++; if (drop3 !== 1'b1) begin errors++; $display("FAIL oor_drop[%0d]: got %b expected 1", i, drop3); end
      checks++; if (y3_valid !== 3'b000) begin errors++; $display("FAIL oor_valid[%0d]: got %b expected 000", i, y3_valid); end
    end
    in3_valid = 1'b1; d3 = 8'h5A; s3 = 2'd0; last3 = 1'b1;
    cycle(1'b0, 8'h00, 2'd0, 1'b0, 4'b1111);
    in3_valid = 1'b0;
    checks++; if (drop3 !== 1'b0) begin errors++; $display("FAIL oor_next_drop: got %b expected 0", drop3); end
    checks++; if (y3_valid !== 3'b001 || y3[7:0] !== 8'h5A) begin errors++; $display("FAIL oor_next_route: got %b/%h expected 001/5a", y3_valid, y3[7:0]); end
    cycle(1'b0, 8'h00, 2'd0, 1'b0, 4'b1111);
  endtask

  task automatic test_counters();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
`ifdef DEMUX_COUNT_EN
    for (int i = 0; i < 65537; i++) begin
      cycle(1'b1, 8'(i), 2'd0, 1'b1, 4'b1111);
    end
    checks++; if (cnt !== 64'h0000_0000_0000_0001) begin errors++; $display("FAIL cnt_wrap: got %h expected 0000000000000001", cnt); end
`else
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, 8'(i), 2'(i % 4), 1'b1, 4'b1111);
    end
    checks++; if (cnt !== 64'd0) begin errors++; $display("FAIL cnt_tied: got %h expected 0", cnt); end
`endif
    checks++; if (cnt !== exp_cnt()) begin errors++; $display("FAIL cnt_model: got %h expected %h", cnt, exp_cnt()); end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; d = '0; s = '0; last = 1'b0; y_ready = 4'b1111;
    in3_valid = 1'b0; d3 = '0; s3 = '0; last3 = 1'b0; y3_ready = 3'b111;
    model_reset();
    test_reset();
    test_packet_lock();
    test_backpressure();
    test_throughput();
    test_out_of_range();
    test_random();
    test_counters();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_demux_n.md
# stream_demux_n

Parametrised, registered 1-to-CHANNELS stream demultiplexer with a valid/ready handshake on every port and packet-granular routing. The destination select is sampled on the first beat of a packet and held until the beat marked LAST is accepted. Each output has a one-entry register. It generalises the combinational 1-to-4 demux tree to arbitrary data width and channel count, and adds flow control and out-of-range drop handling. It sits between a single producer (e.g. instruction or operand fetch) and several consumer units.

## Interface
- WIDTH, 8, data bits per beat
- CHANNELS, 4, number of outputs (≥2)
- SELW, 2, select width; must satisfy 2^SELW ≥ CHANNELS
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- D  in  WIDTH  input beat data
- S  in  SELW  destination channel, sampled only on the first beat of a packet
- LAST  in  1  marks final beat of a packet
- IN_VALID  in  1  input beat valid
- IN_READY  out  1  block can accept a beat this cycle
- Y  out  CHANNELS*WIDTH  output data; channel k at bits [k*WIDTH +: WIDTH]
- Y_LAST  out  CHANNELS  per-channel LAST
- Y_VALID  out  CHANNELS  per-channel valid
- Y_READY  in  CHANNELS  per-channel ready
- DROP  out  1  one-cycle pulse per discarded beat
- CNT  out  CHANNELS*16  per-channel accepted-beat counters; channel k at [k*16 +: 16]

## Operation
- Accept = IN_VALID & IN_READY. Out = Y_VALID[k] & Y_READY[k].
- State machine:
  - IDLE: target t = S.
  - LOCKED: t = registered lock_sel; S is ignored.
  - DROPPING: the current packet is discarded.
- IDLE transitions:
  - Accept with S < CHANNELS and !LAST → LOCKED, lock_sel ← S.
  - Accept with S < CHANNELS and LAST → stay IDLE.
  - Accept with S ≥ CHANNELS and !LAST → DROPPING.
  - Accept with S ≥ CHANNELS and LAST → stay IDLE (single-beat packet dropped).
- LOCKED: accept with LAST → IDLE.
- DROPPING: accept with LAST → IDLE.
- IN_READY:
  - 1 in DROPPING.
  - 1 in IDLE when S ≥ CHANNELS.
  - Otherwise equals ~Y_VALID[t] | Y_READY[t] (full-throughput pass-through ready).
- On a routed accept, slot t loads D/LAST and Y_VALID[t] ← 1.
- A slot draining in the same cycle as it reloads stays valid with the new beat.
- On a dropped accept, no slot changes and DROP = 1 for the following cycle.
- Slot with Out and no reload: Y_VALID[k] ← 0. Y and Y_LAST hold their values.
- While Y_VALID[k] & !Y_READY[k], Y[k] and Y_LAST[k] must stay stable.
- Non-target channels drain independently. Back-pressure on channel t never blocks the other channels' outputs.
- Reset values: Y_VALID=0, Y=0, Y_LAST=0, DROP=0, CNT=0, state=IDLE, lock_sel=0.
- Reset mid-packet discards all slot contents and releases the lock. The next accepted beat after reset is treated as a packet start.

## Timing
- Latency: accept at edge n → Y_VALID[t] high after edge n, consumable in cycle n+1.
- Sustained 1 beat/cycle to a channel while its Y_READY is held high.
- IN_READY depends combinationally on S, the state and Y_READY. No other combinational input-to-output paths exist.
- DROP is registered and asserts one cycle after the dropped accept.

## Configuration
- DEMUX_COUNT_EN defined: CNT[k] increments by 1 on each routed accept to channel k. It wraps 0xFFFF→0x0000 and is cleared by RST.
- DEMUX_COUNT_EN undefined: CNT is tied to 0 and no counter flops exist. All other behaviour is identical.

## Test plan
- Reset: assert RST mid-packet (LOCKED, slot 2 full) → all Y_VALID=0, Y=0, DROP=0. Next beat with S=1, LAST=1 appears on Y_VALID[1] only.
- Packet lock: WIDTH=8, CHANNELS=4, packet 0xA1, 0xA2, 0xA3(LAST) with S=2, then S changed to 0 on beats 2–3 → all three beats are delivered on channel 2, in order, with Y_LAST only on 0xA3.
- Back-pressure: Y_READY[1]=0 while streaming to channel 1 → IN_READY=0 after one beat, Y[1] held stable. Channel 3's pending beat still drains when Y_READY[3]=1. Releasing Y_READY[1] resumes at 1 beat/cycle.
- Out-of-range: CHANNELS=3, S=3, 3-beat packet → IN_READY=1 throughout, DROP pulses 3 times, no Y_VALID. The next packet with S=0 is routed normally.
- Throughput/simultaneous: Y_READY all 1, 8 back-to-back single-beat packets cycling S=0..3 → one output valid per cycle, 1-cycle latency, no bubbles.
- Counters (DEMUX_COUNT_EN): 65537 beats to channel 0 → CNT[0]=1, other channels 0. Without the macro, CNT=0 throughout.
